// File: rtl/cordic_pkg.sv
// Shared types and constant helpers for the iterative CORDIC angle sequencer.
// Angles are unsigned, and full scale (2^DSIZE) represents 90 degrees.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DSIZE_DEF = 16;
    localparam int ITER_DEF  = 16;
    localparam int IW_DEF    = $clog2(ITER_DEF + 1);

    function automatic int iw_of(input int iter);
        return $clog2(iter + 1);
    endfunction

    // atan(2^-i) is taken from its Taylor series. This keeps the table a pure
    // elaboration-time constant without needing a math library.
    function automatic int atan_const(input int i, input int dsize);
        real x;
        real x2;
        real term;
        real sum;
        real scale;
        if (i == 0) begin
            return 1 << (dsize - 1);
        end
        x = 1.0;
        for (int k = 0; k < i; k++) begin
            x = x / 2.0;
        end
        x2    = x * x;
        term  = x;
        sum   = 0.0;
        for (int k = 0; k < 40; k++) begin
            sum  = sum + term / real'(2 * k + 1);
            term = -term * x2;
        end
        scale = (2.0 ** dsize) * 2.0 / 3.14159265358979323846;
        return $rtoi(sum * scale + 0.5);
    endfunction

endpackage

// File: rtl/rotation_seq_if.sv
// Handshake bundle between the angle source, the sequencer and the result consumer.
interface rotation_seq_if #(
    parameter int DSIZE = 16,
    parameter int ITER  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] in_angle;
    logic             out_valid;
    logic             out_ready;
    logic [ITER-1:0]  out_dirs;
    logic [DSIZE-1:0] out_resid;
    logic             busy;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_dirs, out_resid, busy
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_dirs, out_resid, busy
    );
endinterface

// File: rtl/rotation_seq_rotation.sv
// Registered compare-subtract stage: subtracts comp from idata only when no borrow would occur.
module rotation #(
    parameter int DSIZE = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] idata,
    input  logic [DSIZE-1:0] comp,
    output logic [DSIZE-1:0] odata,
    output logic             cmp_rel
);
    logic [DSIZE-1:0] odata_d;
    logic             cmp_rel_d;

    always_comb begin
        cmp_rel_d = (idata >= comp);
        odata_d   = cmp_rel_d ? (idata - comp) : idata;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            odata   <= '0;
            cmp_rel <= 1'b0;
        end else begin
            odata   <= odata_d;
            cmp_rel <= cmp_rel_d;
        end
    end
endmodule

// File: rtl/rotation_seq.sv
// Sequencer that runs one angle through ITER passes of the rotation stage.
// It collects the direction bits and the final residual.
module rotation_seq #(
    parameter int DSIZE = 16,
    parameter int ITER  = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    rotation_seq_if.slave bus
);
    import cordic_pkg::*;

    localparam int IW = iw_of(ITER);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DSIZE-1:0] angle_q, angle_d;
    logic [ITER-1:0]  dirs_q, dirs_d;
    logic [DSIZE-1:0] resid_q, resid_d;

    logic [DSIZE-1:0] stage_idata;
    logic [DSIZE-1:0] stage_comp;
    logic [DSIZE-1:0] stage_odata;
    logic             stage_cmp_rel;
    logic             accept;

    // The extra entry at index ITER is zero, which lets the final pass only flush the stage.
    logic [DSIZE-1:0] atan_rom [ITER+1];

    for (genvar gi = 0; gi <= ITER; gi++) begin : g_atan
        if (gi < ITER) begin : g_val
            localparam int C = atan_const(gi, DSIZE);
            assign atan_rom[gi] = DSIZE'(C);
        end else begin : g_zero
            assign atan_rom[gi] = '0;
        end
    end

    assign stage_idata = (idx_q == '0) ? angle_q : stage_odata;
    assign stage_comp  = atan_rom[idx_q];

    rotation #(
        .DSIZE (DSIZE)
    ) u_stage (
        .clock   (clock),
        .rst_n   (rst_n),
        .idata   (stage_idata),
        .comp    (stage_comp),
        .odata   (stage_odata),
        .cmp_rel (stage_cmp_rel)
    );

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_dirs  = dirs_q;
    assign bus.out_resid = resid_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        angle_d = angle_q;
        dirs_d  = dirs_q;
        resid_d = resid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    angle_d = bus.in_angle;
                    idx_d   = '0;
                    dirs_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The stage output lags by one cycle, so pass idx stores the bit of pass idx-1.
                for (int i = 0; i < ITER; i++) begin
                    if (idx_q == IW'(i + 1)) begin
                        dirs_d[i] = stage_cmp_rel;
                    end
                end
                if (idx_q == IW'(ITER)) begin
                    resid_d = stage_odata;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            angle_q <= '0;
            dirs_q  <= '0;
            resid_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            angle_q <= angle_d;
            dirs_q  <= dirs_d;
            resid_q <= resid_d;
        end
    end
endmodule

// File: tb/tb_rotation_seq.sv
// Randomized bench for rotation_seq, checked against a greedy arctangent-sum model.
module tb_rotation_seq;
    localparam int DSIZE = 16;
    localparam int ITER  = 16;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int txn_no  = 0;
    int unsigned atan_tab [ITER];

    rotation_seq_if #(.DSIZE(DSIZE), .ITER(ITER)) bus ();

    rotation_seq #(
        .DSIZE (DSIZE),
        .ITER  (ITER)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Greedy reference: subtract each arctangent whenever it still fits in the remaining angle.
    function automatic void golden(input logic [DSIZE-1:0] a,
                                   output logic [ITER-1:0] d,
                                   output logic [DSIZE-1:0] r);
        int unsigned rem;
        rem = a;
        d   = '0;
        for (int i = 0; i < ITER; i++) begin
            if (rem >= atan_tab[i]) begin
                rem  = rem - atan_tab[i];
                d[i] = 1'b1;
            end
        end
        r = DSIZE'(rem);
    endfunction

    task automatic run_txn(input logic [DSIZE-1:0] a, input logic [ITER-1:0] exp_d,
                           input logic [DSIZE-1:0] exp_r, input int hold);
        int lat;
        int hs_bad;
        logic [ITER-1:0]  held_d;
        logic [DSIZE-1:0] held_r;
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        step();
        bus.in_valid = 1'b0;
        lat    = 0;
        hs_bad = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hs_bad++;
            step();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd17);
        check_eq("run_handshake", 32'(hs_bad), 32'd0);
        check_eq("out_dirs", 32'(bus.out_dirs), 32'(exp_d));
        check_eq("out_resid", 32'(bus.out_resid), 32'(exp_r));
        held_d = bus.out_dirs;
        held_r = bus.out_resid;
        hs_bad = 0;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_angle = DSIZE'($urandom);
            step();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.out_dirs !== held_d || bus.out_resid !== held_r) hs_bad++;
        end
        if (hold > 0) check_eq("done_hold", 32'(hs_bad), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check_eq("idle_ready", 32'({bus.busy, bus.in_ready}), 32'b01);
        $display("[TB] txn %0d angle=%0d dirs=0x%04h resid=%0d exp_dirs=0x%04h exp_resid=%0d",
                 txn_no, a, held_d, held_r, exp_d, exp_r);
        txn_no++;
    endtask

    initial begin
        logic [ITER-1:0]  ed;
        logic [DSIZE-1:0] er;
        logic [DSIZE-1:0] a;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = int'($floor($atan(2.0 ** (-i)) * (2.0 ** DSIZE) /
                                      (3.14159265358979323846 / 2.0) + 0.5));
        end
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_outputs", 32'({bus.out_valid, bus.busy}), 32'd0);
        check_eq("rst_dirs", 32'(bus.out_dirs), 32'd0);
        check_eq("rst_resid", 32'(bus.out_resid), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        run_txn(16'd0, 16'h0000, 16'd0, 0);
        run_txn(16'd32768, 16'h0001, 16'd0, 0);
        run_txn(16'd52112, 16'h0003, 16'd0, 0);
        golden(16'd65535, ed, er);
        run_txn(16'd65535, ed, er, 5);
        golden(16'd1, ed, er);
        run_txn(16'd1, ed, er, 0);

        for (int n = 0; n < 1000; n++) begin
            a = DSIZE'($urandom);
            golden(a, ed, er);
            run_txn(a, ed, er, int'($urandom_range(0, 3)));
        end

        // Abort a run at idx = 5, then check that the next result carries nothing stale.
        golden(16'd65535, ed, er);
        run_txn(16'd65535, ed, er, 0);
        bus.in_valid = 1'b1;
        bus.in_angle = 16'd12345;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        check_eq("abort_outputs", 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'd0);
        check_eq("abort_dirs", 32'(bus.out_dirs), 32'd0);
        check_eq("abort_resid", 32'(bus.out_resid), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("abort_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_eq("abort_idle", 32'({bus.out_valid, bus.busy}), 32'd0);
        run_txn(16'd32768, 16'h0001, 16'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
